// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, drives the combinational ROM port
// and captures the fetched word into the IF/ID register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o,
  output logic [31:0]       fetch_cnt_o
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc;
  logic              id_bubble;
  logic              id_hold;

  assign rom_addr_o = pc;

  // Chip enable comes up one edge after reset release, so the first fetch
  // uses RESET_PC on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rom_ce_o <= 1'b0;
    else     rom_ce_o <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                pc <= PC_RST;
    else if (!rom_ce_o)     pc <= PC_RST;
    else if (flush_i)       pc <= {new_pc_i[ADDR_W-1:2], 2'b00};
    else if (stall_i[0])    pc <= pc;
    else if (branch_flag_i) pc <= {branch_target_i[ADDR_W-1:2], 2'b00};
    else                    pc <= pc + ADDR_W'(4);
  end

  // Flush beats every stall; a taken branch kills the sequential wrong-path word.
  always_comb begin
    id_bubble = 1'b0;
    id_hold   = 1'b0;
    if (flush_i)                       id_bubble = 1'b1;
    else if (stall_i[1] && !stall_i[2]) id_bubble = 1'b1;
    else if (stall_i[1] && stall_i[2])  id_hold   = 1'b1;
    else if (branch_flag_i)            id_bubble = 1'b1;
    else if (!rom_ce_o)                id_bubble = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_o     <= '0;
      id_inst_o   <= '0;
      id_valid_o  <= 1'b0;
      fetch_cnt_o <= '0;
    end else if (id_bubble) begin
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
    end else if (!id_hold) begin
      id_pc_o     <= pc;
      id_inst_o   <= rom_inst_i;
      id_valid_o  <= 1'b1;
      fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: each driven cycle pushes the expected
// post-edge state, which is popped and compared once the edge has happened.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic [31:0] fetch_cnt_o;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o),
    .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk = ~clk;

  // ROM word[i] = i + 0x100
  assign rom_inst_i = (rom_addr_o >> 2) + 32'h100;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] idpc;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic        m_ce, m_valid;
  logic [31:0] m_pc, m_idpc, m_inst, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ce = 0; m_pc = 0; m_idpc = 0; m_inst = 0; m_valid = 0; m_cnt = 0;
  endtask

  // Drive one cycle of stimulus, predict, wait for the edge, compare.
  task automatic cyc(input logic [2:0] st, input logic fl, input logic [31:0] np,
                     input logic br, input logic [31:0] bt);
    exp_t e, g;
    stall_i = st; flush_i = fl; new_pc_i = np; branch_flag_i = br; branch_target_i = bt;
    e.ce = 1'b1;
    if (!m_ce)      e.addr = 32'h0;
    else if (fl)    e.addr = np & ~32'h3;
    else if (st[0]) e.addr = m_pc;
    else if (br)    e.addr = bt & ~32'h3;
    else            e.addr = m_pc + 32'd4;
    e.idpc = 0; e.inst = 0; e.valid = 0; e.cnt = m_cnt;
    if (fl || (st[1] && !st[2]) || (!(st[1] && st[2]) && (br || !m_ce))) ;
    else if (st[1] && st[2]) begin
      e.idpc = m_idpc; e.inst = m_inst; e.valid = m_valid;
    end else begin
      e.idpc = m_pc; e.inst = (m_pc >> 2) + 32'h100; e.valid = 1; e.cnt = m_cnt + 1;
    end
    q.push_back(e);
    @(posedge clk); #1;
    g = q.pop_front();
    chk("ce",    {31'b0, rom_ce_o},   {31'b0, g.ce});
    chk("addr",  rom_addr_o,          g.addr);
    chk("idpc",  id_pc_o,             g.idpc);
    chk("inst",  id_inst_o,           g.inst);
    chk("valid", {31'b0, id_valid_o}, {31'b0, g.valid});
    chk("cnt",   fetch_cnt_o,         g.cnt);
    m_ce = g.ce; m_pc = g.addr; m_idpc = g.idpc; m_inst = g.inst;
    m_valid = g.valid; m_cnt = g.cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    chk("rst_ce",    {31'b0, rom_ce_o},   32'h0);
    chk("rst_addr",  rom_addr_o,          32'h0);
    chk("rst_inst",  id_inst_o,           32'h0);
    chk("rst_valid", {31'b0, id_valid_o}, 32'h0);
    chk("rst_cnt",   fetch_cnt_o,         32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // start-up + sequential fetch
    for (int i = 0; i < 5; i++) cyc(3'b000, 0, 0, 0, 0);
    chk("seq_cnt",  fetch_cnt_o, 32'd4);
    chk("seq_inst", id_inst_o,   32'h103);

    // stall hold, then single bubble
    cyc(3'b111, 0, 0, 0, 0);
    cyc(3'b111, 0, 0, 0, 0);
    chk("hold_cnt", fetch_cnt_o, 32'd4);
    cyc(3'b011, 0, 0, 0, 0);
    chk("stall_bubble", {31'b0, id_valid_o}, 32'h0);
    cyc(3'b000, 0, 0, 0, 0);

    // branch redirect, then unaligned target
    cyc(3'b000, 0, 0, 1, 32'h40);
    chk("br_addr", rom_addr_o, 32'h40);
    cyc(3'b000, 0, 0, 0, 0);
    chk("br_inst", id_inst_o, 32'h110);
    cyc(3'b000, 0, 0, 1, 32'h43);
    chk("br_align", rom_addr_o, 32'h40);
    cyc(3'b001, 0, 0, 1, 32'h80);
    cyc(3'b000, 0, 0, 0, 0);

    // flush beats stall and branch
    cyc(3'b111, 1, 32'h20, 1, 32'h80);
    chk("fl_addr", rom_addr_o, 32'h20);
    cyc(3'b000, 0, 0, 0, 0);
    cyc(3'b000, 0, 0, 0, 0);

    // wrap at top of address space
    cyc(3'b000, 1, 32'hFFFF_FFFA, 0, 0);
    cyc(3'b000, 0, 0, 0, 0);
    chk("wrap_pre", rom_addr_o, 32'hFFFF_FFFC);
    cyc(3'b000, 0, 0, 0, 0);
    chk("wrap_addr", rom_addr_o, 32'h0);
    cyc(3'b000, 0, 0, 0, 0);

    // async reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("arst_ce",    {31'b0, rom_ce_o},   32'h0);
    chk("arst_valid", {31'b0, id_valid_o}, 32'h0);
    chk("arst_inst",  id_inst_o,           32'h0);
    chk("arst_cnt",   fetch_cnt_o,         32'h0);
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) cyc(3'b000, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
